// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with count enable, parallel load, clock-enable prescaler,
// registered terminal-count pulse and zero flag. Define COUNTER_SATURATE_EN to saturate instead of wrap.
module param_updown_counter #(
  parameter int WIDTH     = 3,
  parameter int RESET_VAL = 0,
  parameter int PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             zero
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);

  logic [PW-1:0]    pre_cnt;
  logic             step;
  logic             at_term;
  logic [WIDTH-1:0] q_step;

  assign step    = en && (pre_cnt == PRE_MAX);
  // Terminal value depends on the direction in force at the step.
  assign at_term = up ? (&q) : (q == '0);

  always_comb begin
    q_step = up ? q + 1'b1 : q - 1'b1;
`ifdef COUNTER_SATURATE_EN
    if (at_term) q_step = q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= RST_Q;
      pre_cnt <= '0;
      tc      <= 1'b0;
    end else if (load) begin
      q       <= load_val;
      pre_cnt <= '0;
      tc      <= 1'b0;
    end else begin
      if (en) pre_cnt <= (pre_cnt == PRE_MAX) ? '0 : pre_cnt + 1'b1;
      if (step) q <= q_step;
      tc <= step && at_term;
    end
  end

  assign zero = (q == '0);
endmodule
